// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - phase encoding, XGA default timing and total-count helper for vga_timing_gen
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int XGA_H_RES  = 1024;
  localparam int XGA_H_FP   = 24;
  localparam int XGA_H_SYNC = 136;
  localparam int XGA_H_BP   = 160;
  localparam int XGA_V_RES  = 768;
  localparam int XGA_V_FP   = 3;
  localparam int XGA_V_SYNC = 6;
  localparam int XGA_V_BP   = 29;

  function automatic int total_count(input int res, input int fp, input int sync_w, input int bp);
    return res + fp + sync_w + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter, ACTIVE/FRONT/SYNC/BACK phase FSM and sync output
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int RES  = XGA_H_RES,
  parameter int FP   = XGA_H_FP,
  parameter int SYNC = XGA_H_SYNC,
  parameter int BP   = XGA_H_BP,
  parameter bit POL  = 1'b0,
  parameter int W    = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic [1:0]   phase,
  output logic         sync,
  output logic         wrap
);

  localparam int TOTAL = total_count(RES, FP, SYNC, BP);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] B_FRONT = W'(RES);
  localparam logic [W-1:0] B_SYNC  = W'(RES + FP);
  localparam logic [W-1:0] B_BACK  = W'(RES + FP + SYNC);

  phase_t       phase_q;
  phase_t       phase_nxt;
  logic [W-1:0] count_nxt;

  assign wrap  = (count == LAST);
  assign phase = phase_q;

  always_comb begin
    count_nxt = count;
    phase_nxt = phase_q;
    if (step) begin
      count_nxt = wrap ? '0 : count + W'(1);
      // Phase is decoded from the next count so sync lines up with the position it describes
      if (count_nxt == '0)          phase_nxt = PH_ACTIVE;
      else if (count_nxt == B_FRONT) phase_nxt = PH_FRONT;
      else if (count_nxt == B_SYNC)  phase_nxt = PH_SYNC;
      else if (count_nxt == B_BACK)  phase_nxt = PH_BACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= LAST;
      phase_q <= PH_BACK;
      sync    <= ~POL;
    end else begin
      count   <= count_nxt;
      phase_q <= phase_nxt;
      sync    <= (phase_nxt == PH_SYNC) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing controller; VGA_FRAME_CNT_EN adds the frame_cnt output
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_RES  = XGA_H_RES,
  parameter int H_FP   = XGA_H_FP,
  parameter int H_SYNC = XGA_H_SYNC,
  parameter int H_BP   = XGA_H_BP,
  parameter int V_RES  = XGA_V_RES,
  parameter int V_FP   = XGA_V_FP,
  parameter int V_SYNC = XGA_V_SYNC,
  parameter int V_BP   = XGA_V_BP,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int H_DIM  = 11,
  parameter int V_DIM  = 10
) (
  input  logic           pix_clk,
  input  logic           rst_n,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           disp_en,
  output logic [H_DIM:0] pos_x,
  output logic [V_DIM:0] pos_y,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]     frame_cnt
`endif
);

  localparam int H_TOTAL = total_count(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total_count(V_RES, V_FP, V_SYNC, V_BP);
  localparam logic [H_DIM:0] H_ACT_LAST = (H_DIM + 1)'(H_RES - 1);
  localparam logic [V_DIM:0] V_ACT_LAST = (V_DIM + 1)'(V_RES - 1);

  if (H_TOTAL > (1 << (H_DIM + 1)) || V_TOTAL > (1 << (V_DIM + 1)) ||
      H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_cfg_check
    $error("vga_timing_gen: timing parameters do not fit the counters or a porch/sync is zero");
  end

  logic [1:0] h_phase;
  logic [1:0] v_phase;
  logic       h_wrap;
  logic       v_wrap;
  logic       v_step;
  logic       h_act_nxt;
  logic       v_act_nxt;

  assign v_step = en && h_wrap;

  vga_axis_counter #(
    .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(H_DIM + 1)
  ) u_h (
    .clk(pix_clk), .rst_n(rst_n), .step(en),
    .count(pos_x), .phase(h_phase), .sync(hsync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(V_DIM + 1)
  ) u_v (
    .clk(pix_clk), .rst_n(rst_n), .step(v_step),
    .count(pos_y), .phase(v_phase), .sync(vsync), .wrap(v_wrap)
  );

  // Activity of the next position, assuming the horizontal axis steps this cycle
  always_comb begin
    h_act_nxt = h_wrap || ((h_phase == PH_ACTIVE) && (pos_x != H_ACT_LAST));
    v_act_nxt = (v_phase == PH_ACTIVE);
    if (v_step) v_act_nxt = v_wrap || ((v_phase == PH_ACTIVE) && (pos_y != V_ACT_LAST));
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      disp_en     <= h_act_nxt && v_act_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n)                    frame_cnt <= 8'd0;
    else if (en && h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule
